// File: rtl/y86_pkg.sv
// Shared Y86-64 constants, slot record and forwarding encodings for the hazard controller.
package y86_pkg;

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;

  typedef enum logic [2:0] {
    FWD_REG    = 3'd0,
    FWD_E_VALE = 3'd1,
    FWD_M_VALM = 3'd2,
    FWD_M_VALE = 3'd3,
    FWD_W_VALM = 3'd4,
    FWD_W_VALE = 3'd5
  } fwd_sel_t;

  typedef enum logic {
    RET_IDLE = 1'b0,
    RET_WAIT = 1'b1
  } ret_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] icode;
    logic [3:0] dstE;
    logic [3:0] dstM;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, icode: INOP, dstE: RNONE, dstM: RNONE};

  // RNONE names no register, so it never produces a dependency.
  function automatic logic reg_match(input logic [3:0] src, input logic [3:0] dst);
    return (src != RNONE) && (src == dst);
  endfunction

  function automatic logic slot_hit(input slot_t s, input logic [3:0] src);
    return s.valid && (reg_match(src, s.dstE) || reg_match(src, s.dstM));
  endfunction

endpackage

// File: rtl/inflight_tracker.sv
// E/M/W in-flight slot shift register; E takes the decode fields or becomes a bubble.
module inflight_tracker
  import y86_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_en,
  input  logic [3:0] d_icode,
  input  logic [3:0] d_dstE,
  input  logic [3:0] d_dstM,
  output slot_t      e_slot,
  output slot_t      m_slot,
  output slot_t      w_slot
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_slot <= SLOT_EMPTY;
      m_slot <= SLOT_EMPTY;
      w_slot <= SLOT_EMPTY;
    end else begin
      w_slot <= m_slot;
      m_slot <= e_slot;
      if (load_en) begin
        e_slot <= '{valid: 1'b1, icode: d_icode, dstE: d_dstE, dstM: d_dstM};
      end else begin
        e_slot <= SLOT_EMPTY;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86 pipeline hazard controller: load-use, mispredict and ret handling plus operand forwarding.
// Forwarding is enabled with `define PIPE_HAZARD_FWD_EN; otherwise every data dependency stalls.
module pipe_hazard_ctrl
  import y86_pkg::*;
#(
  parameter int RET_BUBBLES = 3
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d_valid,
  input  logic [3:0] d_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] d_dstE,
  input  logic [3:0] d_dstM,
  input  logic       e_cnd,
  output logic       f_stall,
  output logic       d_stall,
  output logic       d_bubble,
  output logic       e_bubble,
  output logic [2:0] fwdA_sel,
  output logic [2:0] fwdB_sel
);

  slot_t      e_slot;
  slot_t      m_slot;
  slot_t      w_slot;
  ret_state_t ret_state;
  logic [2:0] ret_cnt;

  logic       mispredict;
  logic       load_use;
  logic       data_stall;
  logic       ret_in_d;
  logic       ret_hold;
  logic       ret_enter;
  logic       load_en;
  fwd_sel_t   fwd_a;
  fwd_sel_t   fwd_b;

  // Later-stage icodes only travel down the pipe; nothing downstream inspects them.
  logic       unused_icodes;
  assign unused_icodes = ^{m_slot.icode, w_slot.icode};

  assign mispredict = e_slot.valid && (e_slot.icode == IJXX) && !e_cnd;
  assign load_use   = d_valid && e_slot.valid &&
                      ((e_slot.icode == IMRMOVQ) || (e_slot.icode == IPOPQ)) &&
                      (reg_match(d_srcA, e_slot.dstM) || reg_match(d_srcB, e_slot.dstM));
  assign ret_in_d   = d_valid && (d_icode == IRET);
  assign ret_hold   = ret_in_d || (ret_state == RET_WAIT);

`ifdef PIPE_HAZARD_FWD_EN
  function automatic fwd_sel_t pick_fwd(input logic [3:0] src, input slot_t e,
                                        input slot_t m, input slot_t w);
    if (e.valid && reg_match(src, e.dstE)) return FWD_E_VALE;
    if (m.valid && reg_match(src, m.dstM)) return FWD_M_VALM;
    if (m.valid && reg_match(src, m.dstE)) return FWD_M_VALE;
    if (w.valid && reg_match(src, w.dstM)) return FWD_W_VALM;
    if (w.valid && reg_match(src, w.dstE)) return FWD_W_VALE;
    return FWD_REG;
  endfunction

  assign data_stall = load_use;
  assign fwd_a      = pick_fwd(d_srcA, e_slot, m_slot, w_slot);
  assign fwd_b      = pick_fwd(d_srcB, e_slot, m_slot, w_slot);
`else
  assign data_stall = load_use ||
                      (d_valid && (slot_hit(e_slot, d_srcA) || slot_hit(e_slot, d_srcB) ||
                                   slot_hit(m_slot, d_srcA) || slot_hit(m_slot, d_srcB) ||
                                   slot_hit(w_slot, d_srcA) || slot_hit(w_slot, d_srcB)));
  assign fwd_a      = FWD_REG;
  assign fwd_b      = FWD_REG;
`endif

  // Mispredict squashes the wrong path first; a data stall freezes decode, so d_bubble stays low.
  always_comb begin
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    d_bubble = 1'b0;
    e_bubble = 1'b0;
    fwdA_sel = FWD_REG;
    fwdB_sel = FWD_REG;
    if (rst_n) begin
      fwdA_sel = fwd_a;
      fwdB_sel = fwd_b;
      if (mispredict) begin
        d_bubble = 1'b1;
        e_bubble = 1'b1;
      end else if (data_stall) begin
        f_stall  = 1'b1;
        d_stall  = 1'b1;
        e_bubble = 1'b1;
      end else if (ret_hold) begin
        f_stall  = 1'b1;
        d_bubble = 1'b1;
      end
    end
  end

  assign load_en   = d_valid && !d_stall && !e_bubble;
  assign ret_enter = ret_in_d && !d_stall && !mispredict;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ret_state <= RET_IDLE;
      ret_cnt   <= 3'd0;
    end else begin
      case (ret_state)
        RET_IDLE: begin
          if (ret_enter) begin
            ret_state <= RET_WAIT;
            ret_cnt   <= 3'(RET_BUBBLES - 1);
          end
        end
        RET_WAIT: begin
          if (ret_cnt == 3'd0) begin
            ret_state <= RET_IDLE;
          end else begin
            ret_cnt <= ret_cnt - 3'd1;
          end
        end
        default: begin
          ret_state <= RET_IDLE;
          ret_cnt   <= 3'd0;
        end
      endcase
    end
  end

  inflight_tracker u_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_en (load_en),
    .d_icode (d_icode),
    .d_dstE  (d_dstE),
    .d_dstM  (d_dstM),
    .e_slot  (e_slot),
    .m_slot  (m_slot),
    .w_slot  (w_slot)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected controls, a monitor checks them.
module tb_pipe_hazard_ctrl;

  localparam logic [3:0] N     = 4'hF;
  localparam logic [3:0] RAX   = 4'h0;
  localparam logic [3:0] RCX   = 4'h1;
  localparam logic [3:0] RDX   = 4'h2;
  localparam logic [3:0] RBX   = 4'h3;
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] NOP   = 4'h1;
  localparam logic [3:0] MRMOV = 4'h5;
  localparam logic [3:0] OPQ   = 4'h6;
  localparam logic [3:0] JXX   = 4'h7;
  localparam logic [3:0] RET   = 4'h9;
  localparam logic [3:0] POPQ  = 4'hB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d_valid;
  logic [3:0] d_icode;
  logic [3:0] d_srcA;
  logic [3:0] d_srcB;
  logic [3:0] d_dstE;
  logic [3:0] d_dstM;
  logic       e_cnd;
  logic       f_stall;
  logic       d_stall;
  logic       d_bubble;
  logic       e_bubble;
  logic [2:0] fwdA_sel;
  logic [2:0] fwdB_sel;

  typedef struct {
    string      name;
    logic [9:0] exp;
  } sb_entry_t;

  sb_entry_t exp_q[$];
  int        n_checks = 0;
  int        n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RET_BUBBLES(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_valid  (d_valid),
    .d_icode  (d_icode),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .d_dstE   (d_dstE),
    .d_dstM   (d_dstM),
    .e_cnd    (e_cnd),
    .f_stall  (f_stall),
    .d_stall  (d_stall),
    .d_bubble (d_bubble),
    .e_bubble (e_bubble),
    .fwdA_sel (fwdA_sel),
    .fwdB_sel (fwdB_sel)
  );

  function automatic logic [9:0] ex(input logic f, input logic ds, input logic db,
                                    input logic eb, input logic [2:0] fa, input logic [2:0] fb);
    return {f, ds, db, eb, fa, fb};
  endfunction

  task automatic applyStimulus(input string nm, input logic rst, input logic v,
                               input logic [3:0] ic, input logic [3:0] sa, input logic [3:0] sb,
                               input logic [3:0] de, input logic [3:0] dm, input logic cnd,
                               input logic [9:0] exp);
    sb_entry_t ent;
    @(posedge clk);
    #1;
    rst_n   = rst;
    d_valid = v;
    d_icode = ic;
    d_srcA  = sa;
    d_srcB  = sb;
    d_dstE  = de;
    d_dstM  = dm;
    e_cnd   = cnd;
    ent.name = nm;
    ent.exp  = exp;
    exp_q.push_back(ent);
  endtask

  task automatic idleCycles(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(nm, 1'b1, 1'b0, NOP, N, N, N, N, 1'b1, ex(0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic checkOutput(input string nm, input logic [9:0] exp);
    logic [9:0] act;
    act = {f_stall, d_stall, d_bubble, e_bubble, fwdA_sel, fwdB_sel};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got f/ds/db/eb=%b fwdA=%0d fwdB=%0d, expected f/ds/db/eb=%b fwdA=%0d fwdB=%0d",
               nm, act[9:6], act[5:3], act[2:0], exp[9:6], exp[5:3], exp[2:0]);
    end
  endtask

  initial begin : monitor
    sb_entry_t ent;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        ent = exp_q.pop_front();
        checkOutput(ent.name, ent.exp);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int budget;
    rst_n   = 1'b0;
    d_valid = 1'b0;
    d_icode = NOP;
    d_srcA  = N;
    d_srcB  = N;
    d_dstE  = N;
    d_dstM  = N;
    e_cnd   = 1'b1;

    // Reset: outputs forced low even with a ret presented in decode.
    applyStimulus("reset_ret", 1'b0, 1'b1, RET, N, N, N, N, 1'b0, ex(0, 0, 0, 0, 0, 0));
    applyStimulus("reset_idle", 1'b0, 1'b0, NOP, N, N, N, N, 1'b1, ex(0, 0, 0, 0, 0, 0));
    idleCycles("post_reset", 2);

    // Load-use: mrmovq -> %rax, then OPq reading %rax.
    applyStimulus("lu_mrmov", 1'b1, 1'b1, MRMOV, N, RCX, N, RAX, 1'b1, ex(0, 0, 0, 0, 0, 0));
    applyStimulus("lu_stall", 1'b1, 1'b1, OPQ, RAX, RDX, RDX, N, 1'b1, ex(1, 1, 0, 1, 0, 0));
`ifdef PIPE_HAZARD_FWD_EN
    applyStimulus("lu_fwd_mvalm", 1'b1, 1'b1, OPQ, RAX, RDX, RDX, N, 1'b1, ex(0, 0, 0, 0, 2, 0));
`else
    applyStimulus("lu_nofwd_stall", 1'b1, 1'b1, OPQ, RAX, RDX, RDX, N, 1'b1, ex(1, 1, 0, 1, 0, 0));
`endif
    idleCycles("lu_drain", 3);

    // popq load-use through srcB.
    applyStimulus("pop_dec", 1'b1, 1'b1, POPQ, RSP, RSP, RSP, RCX, 1'b1, ex(0, 0, 0, 0, 0, 0));
    applyStimulus("pop_lu_srcB", 1'b1, 1'b1, OPQ, N, RCX, RCX, N, 1'b1, ex(1, 1, 0, 1, 0, 0));
    idleCycles("pop_drain", 3);

    // Mispredict and correctly predicted branch.
    applyStimulus("jxx_dec1", 1'b1, 1'b1, JXX, N, N, N, N, 1'b1, ex(0, 0, 0, 0, 0, 0));
    applyStimulus("jxx_mispred", 1'b1, 1'b1, NOP, N, N, N, N, 1'b0, ex(0, 0, 1, 1, 0, 0));
    applyStimulus("jxx_dec2", 1'b1, 1'b1, JXX, N, N, N, N, 1'b1, ex(0, 0, 0, 0, 0, 0));
    applyStimulus("jxx_taken_ok", 1'b1, 1'b1, NOP, N, N, N, N, 1'b1, ex(0, 0, 0, 0, 0, 0));
    idleCycles("jxx_drain", 3);

    // Wrong-path ret under a mispredict must not start the ret sequence.
    applyStimulus("wp_jxx", 1'b1, 1'b1, JXX, N, N, N, N, 1'b1, ex(0, 0, 0, 0, 0, 0));
    applyStimulus("wp_ret_mispred", 1'b1, 1'b1, RET, N, N, N, N, 1'b0, ex(0, 0, 1, 1, 0, 0));
    applyStimulus("wp_no_retwait1", 1'b1, 1'b0, NOP, N, N, N, N, 1'b0, ex(0, 0, 0, 0, 0, 0));
    applyStimulus("wp_no_retwait2", 1'b1, 1'b0, NOP, N, N, N, N, 1'b1, ex(0, 0, 0, 0, 0, 0));
    idleCycles("wp_drain", 2);

    // ret: decode cycle plus three RET_WAIT bubbles.
    applyStimulus("ret_decode", 1'b1, 1'b1, RET, N, N, N, N, 1'b0, ex(1, 0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("ret_wait%0d", i + 1), 1'b1, 1'b0, NOP, N, N, N, N, 1'b1,
                    ex(1, 0, 1, 0, 0, 0));
    end
    applyStimulus("ret_done", 1'b1, 1'b0, NOP, N, N, N, N, 1'b1, ex(0, 0, 0, 0, 0, 0));
    idleCycles("ret_drain", 2);

    // Reset in the second RET_WAIT cycle aborts the remaining bubbles.
    applyStimulus("rr_decode", 1'b1, 1'b1, RET, N, N, N, N, 1'b0, ex(1, 0, 1, 0, 0, 0));
    applyStimulus("rr_wait1", 1'b1, 1'b0, NOP, N, N, N, N, 1'b1, ex(1, 0, 1, 0, 0, 0));
    applyStimulus("rr_reset", 1'b0, 1'b0, NOP, N, N, N, N, 1'b1, ex(0, 0, 0, 0, 0, 0));
    applyStimulus("rr_idle_after", 1'b1, 1'b0, NOP, N, N, N, N, 1'b1, ex(0, 0, 0, 0, 0, 0));
    idleCycles("rr_drain", 2);

    // OPq -> %rbx sitting in W; decode with srcB=RNONE, then srcB=%rbx.
    applyStimulus("w_opq_none", 1'b1, 1'b1, OPQ, N, N, RBX, N, 1'b1, ex(0, 0, 0, 0, 0, 0));
    idleCycles("w_age_none", 2);
    applyStimulus("w_srcB_rnone", 1'b1, 1'b1, OPQ, N, N, RDX, N, 1'b1, ex(0, 0, 0, 0, 0, 0));
    idleCycles("w_flush", 3);
    applyStimulus("w_opq_rbx", 1'b1, 1'b1, OPQ, N, N, RBX, N, 1'b1, ex(0, 0, 0, 0, 0, 0));
    idleCycles("w_age_rbx", 2);
`ifdef PIPE_HAZARD_FWD_EN
    applyStimulus("w_srcB_fwd_wvale", 1'b1, 1'b1, OPQ, N, RBX, RDX, N, 1'b1, ex(0, 0, 0, 0, 0, 5));
`else
    applyStimulus("w_srcB_stall", 1'b1, 1'b1, OPQ, N, RBX, RDX, N, 1'b1, ex(1, 1, 0, 1, 0, 0));
`endif
    idleCycles("final_drain", 3);

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
